// File: rtl/data_mem_port_arbiter_if.sv
// data_mem_port_arbiter_if
//   Bundles the two requester handshakes (R0 load/store unit, R1 stack unit)
//   and the single memory port shared between them.
//   modport slave  : the arbiter view (takes requests, drives acks and memory strobes)
//   modport master : the environment view (requesters plus the memory itself)
//   Parameter DEPTH_W sizes stack_depth and must match the arbiter's DEPTH_W.
interface data_mem_port_arbiter_if #(
  parameter int DEPTH_W = 4
);
  logic               r0_req;
  logic               r0_we;
  logic [31:0]        r0_addr;
  logic [31:0]        r0_wdata;
  logic               r0_ack;
  logic               r1_req;
  logic               r1_push;
  logic [31:0]        r1_wdata;
  logic               r1_ack;
  logic [31:0]        rsp_data;
  logic               mem_write;
  logic               mem_read;
  logic               dataMemEnable;
  logic [31:0]        mem_address;
  logic [31:0]        mem_data_in;
  logic [31:0]        mem_data_out;
  logic [DEPTH_W-1:0] stack_depth;
  logic               stack_err;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_push, r1_wdata,
    input  mem_data_out,
    output r0_ack, r1_ack, rsp_data,
    output mem_write, mem_read, dataMemEnable, mem_address, mem_data_in,
    output stack_depth, stack_err
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_push, r1_wdata,
    output mem_data_out,
    input  r0_ack, r1_ack, rsp_data,
    input  mem_write, mem_read, dataMemEnable, mem_address, mem_data_in,
    input  stack_depth, stack_err
  );
endinterface

// File: rtl/data_mem_port_arbiter.sv
// data_mem_port_arbiter
//   Shares the single port of data_memory_with_stack between R0 (load/store
//   unit, static region) and R1 (stack unit, push/pop). Round-robin grant,
//   one access in flight, fixed IDLE -> ISSUE -> WAIT -> RESP loop. Tracks
//   stack occupancy in stack_depth.
// Ports
//   clk  : system clock, posedge
//   rst  : asynchronous active-high reset; aborts any access in flight
//   bus  : data_mem_port_arbiter_if.slave -- requester handshakes
//          (r0_*, r1_*, rsp_data), memory port (mem_write, mem_read,
//          dataMemEnable, mem_address, mem_data_in, mem_data_out) and
//          stack status (stack_depth, stack_err)
// Configuration
//   `define STACK_GUARD_EN : push when full / pop when empty is blocked
//     (strobes suppressed, rsp_data=0, ack still given) and flagged on
//     stack_err during RESP. Undefined: stack ops always strobe, the memory
//     drops illegal ones, stack_depth saturates, stack_err is tied 0.
module data_mem_port_arbiter #(
  parameter int STACK_DEPTH = 14,
  parameter int DEPTH_W     = 4
) (
  input logic                     clk,
  input logic                     rst,
  data_mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  state_t             next_state;

  logic               last_grant;   // 0 = R0, 1 = R1
  logic               cur_id;
  logic               cur_we;       // store for R0, push for R1
  logic               blocked;
  logic               mem_enable;
  logic [31:0]        mem_address;
  logic [31:0]        mem_data_in;
  logic [31:0]        rsp_data;
  logic [DEPTH_W-1:0] stack_depth;

  logic               grant_valid;
  logic               grant_id;
  logic               grant_blocked;
  logic               stack_full;
  logic               stack_empty;

  assign stack_full  = (stack_depth == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (stack_depth == {DEPTH_W{1'b0}});

  // Round-robin choice: a tie goes to the requester that was not served last.
  always_comb begin
    grant_valid = bus.r0_req | bus.r1_req;
    if (bus.r0_req && bus.r1_req) begin
      grant_id = ~last_grant;
    end else if (bus.r1_req) begin
      grant_id = 1'b1;
    end else begin
      grant_id = 1'b0;
    end
  end

  // Decide at grant time whether a stack op is out of bounds; depth cannot
  // change between the grant and ISSUE, so the decision stays valid.
  always_comb begin
`ifdef STACK_GUARD_EN
    if (grant_id) begin
      grant_blocked = bus.r1_push ? stack_full : stack_empty;
    end else begin
      grant_blocked = 1'b0;
    end
`else
    grant_blocked = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: fixed loop, leaving IDLE only on a request.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = grant_valid ? ISSUE : IDLE;
      ISSUE:   next_state = WAIT;
      WAIT:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: strobes only in ISSUE, acks only in RESP, everything else from registers.
  always_comb begin
    bus.mem_write     = (state == ISSUE) &&  cur_we && !blocked;
    bus.mem_read      = (state == ISSUE) && !cur_we && !blocked;
    bus.r0_ack        = (state == RESP) && !cur_id;
    bus.r1_ack        = (state == RESP) &&  cur_id;
`ifdef STACK_GUARD_EN
    bus.stack_err     = (state == RESP) && blocked;
`else
    bus.stack_err     = 1'b0;
`endif
    bus.dataMemEnable = mem_enable;
    bus.mem_address   = mem_address;
    bus.mem_data_in   = mem_data_in;
    bus.rsp_data      = rsp_data;
    bus.stack_depth   = stack_depth;
  end

  // Latch the granted request; the memory-side address/data registers hold
  // their values until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= 1'b1;
      cur_id      <= 1'b0;
      cur_we      <= 1'b0;
      blocked     <= 1'b0;
      mem_enable  <= 1'b0;
      mem_address <= 32'd0;
      mem_data_in <= 32'd0;
    end else if (state == IDLE && grant_valid) begin
      cur_id     <= grant_id;
      last_grant <= grant_id;
      blocked    <= grant_blocked;
      if (!grant_id) begin
        cur_we      <= bus.r0_we;
        mem_enable  <= 1'b1;
        mem_address <= bus.r0_addr;
        if (bus.r0_we) begin
          mem_data_in <= bus.r0_wdata;
        end else begin
          mem_data_in <= mem_data_in;
        end
      end else begin
        cur_we      <= bus.r1_push;
        mem_enable  <= 1'b0;
        mem_address <= 32'd0;
        if (bus.r1_push) begin
          mem_data_in <= bus.r1_wdata;
        end else begin
          mem_data_in <= mem_data_in;
        end
      end
    end else begin
      last_grant <= last_grant;
    end
  end

  // Stack occupancy moves at the end of an issued stack op; saturation only
  // matters when the guard is off and illegal ops are let through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stack_depth <= {DEPTH_W{1'b0}};
    end else if (state == ISSUE && cur_id && !blocked) begin
      if (cur_we && !stack_full) begin
        stack_depth <= stack_depth + {{(DEPTH_W-1){1'b0}}, 1'b1};
      end else if (!cur_we && !stack_empty) begin
        stack_depth <= stack_depth - {{(DEPTH_W-1){1'b0}}, 1'b1};
      end else begin
        stack_depth <= stack_depth;
      end
    end else begin
      stack_depth <= stack_depth;
    end
  end

  // Capture the memory's registered read data at the end of WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data <= 32'd0;
    end else if (state == WAIT) begin
      if (!cur_we && !blocked) begin
        rsp_data <= bus.mem_data_out;
      end else begin
        rsp_data <= 32'd0;
      end
    end else begin
      rsp_data <= rsp_data;
    end
  end

endmodule
